fp_compare_unit: RTL



---
 rtl/fpu_pkg.sv | 54 +++++
 rtl/fp_classify.sv | 44 ++++
 rtl/fp_compare_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op encodings, FCLASS bit positions, fflags
// layout, per-operand classification record and IEEE-754 field sizes.
package fpu_pkg;

    // Compare/classify operation encodings
    localparam logic [1:0] FP_FEQ    = 2'b00;
    localparam logic [1:0] FP_FLT    = 2'b01;
    localparam logic [1:0] FP_FLE    = 2'b10;
    localparam logic [1:0] FP_FCLASS = 2'b11;

    // FCLASS result mask bit positions
    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;
    localparam int CLS_W        = 10;

    // Exception flags {NV,DZ,OF,UF,NX}
    localparam int FFLAGS_W  = 5;
    localparam int FFLAG_NV  = 4;

    // Classification of one operand, exactly one of the kind bits is set
    typedef struct packed {
        logic sign;
        logic is_zero;
        logic is_sub;
        logic is_norm;
        logic is_inf;
        logic is_snan;
        logic is_qnan;
    } fp_class_t;

    // Mantissa (fraction) width for a given operand width
    function automatic int fp_man_bits(input int width);
        return (width == 32) ? 23 : 52;
    endfunction

    // Exponent width for a given operand width
    function automatic int fp_exp_bits(input int width);
        return (width == 32) ? 8 : 11;
    endfunction

    // Canonical quiet NaN for a given operand width, zero-extended to 64 bits
    function automatic logic [63:0] fp_canonical_nan(input int width);
        return (width == 32) ? 64'h0000_0000_7FC0_0000 : 64'h7FF8_0000_0000_0000;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier (single or double width).
module fp_classify
    import fpu_pkg::*;
#(
    parameter int BUS_WIDTH = 64
) (
    input  logic [BUS_WIDTH-1:0] op_in,
    output logic                 is_zero,
    output logic                 is_sub,
    output logic                 is_norm,
    output logic                 is_inf,
    output logic                 is_snan,
    output logic                 is_qnan,
    output logic                 sign
);

    localparam int MW = fp_man_bits(BUS_WIDTH);
    localparam int EW = fp_exp_bits(BUS_WIDTH);

    logic [EW-1:0] exp_s;
    logic [MW-1:0] man_s;
    logic          exp_ones_s;
    logic          exp_zero_s;
    logic          man_zero_s;

    assign exp_s      = op_in[BUS_WIDTH-2 -: EW];
    assign man_s      = op_in[MW-1:0];
    assign exp_ones_s = &exp_s;
    assign exp_zero_s = ~|exp_s;
    assign man_zero_s = ~|man_s;

    // Decode exponent/mantissa into the mutually exclusive operand kinds
    always_comb begin
        sign    = op_in[BUS_WIDTH-1];
        is_zero = exp_zero_s & man_zero_s;
        is_sub  = exp_zero_s & ~man_zero_s;
        is_norm = ~exp_zero_s & ~exp_ones_s;
        is_inf  = exp_ones_s & man_zero_s;
        // Mantissa MSB distinguishes quiet from signalling NaN
        is_snan = exp_ones_s & ~man_zero_s & ~man_s[MW-1];
        is_qnan = exp_ones_s & ~man_zero_s & man_s[MW-1];
    end

endmodule

// File: rtl/fp_compare_unit.sv
// Two-stage pipelined FEQ/FLT/FLE/FCLASS unit with valid/ready handshakes.
// Stage 1 captures operand classes and magnitude relations, stage 2
// captures the integer result and NV flag.
module fp_compare_unit
    import fpu_pkg::*;
#(
    parameter int BUS_WIDTH = 64,
    parameter int XLEN      = 64,
    parameter int TAG_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [BUS_WIDTH-1:0] in1,
    input  logic [BUS_WIDTH-1:0] in2,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic [FFLAGS_W-1:0]  out_fflags
);

    localparam int MAG_W = BUS_WIDTH - 1;

    // Operand classification
    logic a_zero_s, a_sub_s, a_norm_s, a_inf_s, a_snan_s, a_qnan_s, a_sign_s;
    logic b_zero_s, b_sub_s, b_norm_s, b_inf_s, b_snan_s, b_qnan_s, b_sign_s;
    logic b_unused_s;
    fp_class_t cls_a_s;
    fp_class_t cls_b_s;
    logic mag_eq_s;
    logic mag_lt_s;

    // Pipeline control
    logic s1_en_s;
    logic s2_en_s;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q,    s1_op_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    fp_class_t        s1_cls_a_q, s1_cls_a_d;
    fp_class_t        s1_cls_b_q, s1_cls_b_d;
    logic             s1_mag_eq_q, s1_mag_eq_d;
    logic             s1_mag_lt_q, s1_mag_lt_d;

    // Stage 2 registers (drive the outputs directly)
    logic                s2_valid_q,  s2_valid_d;
    logic [XLEN-1:0]     s2_result_q, s2_result_d;
    logic [TAG_W-1:0]    s2_tag_q,    s2_tag_d;
    logic [FFLAGS_W-1:0] s2_fflags_q, s2_fflags_d;

    // Stage 2 compute results
    logic             any_nan_s;
    logic             any_snan_s;
    logic             both_zero_s;
    logic             eq_s;
    logic             lt_s;
    logic [CLS_W-1:0] mask_s;
    logic [XLEN-1:0]  result_s;
    logic             nv_s;

    fp_classify #(.BUS_WIDTH(BUS_WIDTH)) u_cls_a (
        .op_in   (in1),
        .is_zero (a_zero_s),
        .is_sub  (a_sub_s),
        .is_norm (a_norm_s),
        .is_inf  (a_inf_s),
        .is_snan (a_snan_s),
        .is_qnan (a_qnan_s),
        .sign    (a_sign_s)
    );

    fp_classify #(.BUS_WIDTH(BUS_WIDTH)) u_cls_b (
        .op_in   (in2),
        .is_zero (b_zero_s),
        .is_sub  (b_sub_s),
        .is_norm (b_norm_s),
        .is_inf  (b_inf_s),
        .is_snan (b_snan_s),
        .is_qnan (b_qnan_s),
        .sign    (b_sign_s)
    );

    assign cls_a_s = {a_sign_s, a_zero_s, a_sub_s, a_norm_s, a_inf_s, a_snan_s, a_qnan_s};
    assign cls_b_s = {b_sign_s, b_zero_s, b_sub_s, b_norm_s, b_inf_s, b_snan_s, b_qnan_s};
    // Operand 2 is only ever compared, its finer kind bits are redundant
    assign b_unused_s = ^{cls_b_s.is_sub, cls_b_s.is_norm, cls_b_s.is_inf};

    // Magnitude (sign stripped) relations; valid ordering for non-NaN values
    assign mag_eq_s = (in1[MAG_W-1:0] == in2[MAG_W-1:0]);
    assign mag_lt_s = (in1[MAG_W-1:0] <  in2[MAG_W-1:0]);

    // A stage advances when its successor is empty or draining
    assign s2_en_s  = ~s2_valid_q | out_ready;
    assign s1_en_s  = ~s1_valid_q | s2_en_s;
    assign in_ready = s1_en_s;

    // Stage 1 next state: capture on handshake, flush kills valid
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;
        s1_cls_a_d  = s1_cls_a_q;
        s1_cls_b_d  = s1_cls_b_q;
        s1_mag_eq_d = s1_mag_eq_q;
        s1_mag_lt_d = s1_mag_lt_q;
        if (s1_en_s && in_valid) begin
            s1_op_d     = in_op;
            s1_tag_d    = in_tag;
            s1_cls_a_d  = cls_a_s;
            s1_cls_b_d  = cls_b_s;
            s1_mag_eq_d = mag_eq_s;
            s1_mag_lt_d = mag_lt_s;
        end else begin
            s1_op_d     = s1_op_q;
        end
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_en_s) begin
            s1_valid_d = in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 compute: compare result, class mask and invalid flag
    always_comb begin
        any_nan_s   = s1_cls_a_q.is_snan | s1_cls_a_q.is_qnan |
                      s1_cls_b_q.is_snan | s1_cls_b_q.is_qnan;
        any_snan_s  = s1_cls_a_q.is_snan | s1_cls_b_q.is_snan;
        both_zero_s = s1_cls_a_q.is_zero & s1_cls_b_q.is_zero;
        eq_s        = ~any_nan_s &
                      (both_zero_s | ((s1_cls_a_q.sign == s1_cls_b_q.sign) & s1_mag_eq_q));
        lt_s        = 1'b0;
        mask_s      = {CLS_W{1'b0}};
        result_s    = {XLEN{1'b0}};
        nv_s        = 1'b0;

        // Sign-magnitude less-than; +0/-0 are equal
        if (any_nan_s || both_zero_s) begin
            lt_s = 1'b0;
        end else if (s1_cls_a_q.sign != s1_cls_b_q.sign) begin
            lt_s = s1_cls_a_q.sign;
        end else if (!s1_cls_a_q.sign) begin
            lt_s = s1_mag_lt_q;
        end else begin
            lt_s = ~s1_mag_lt_q & ~s1_mag_eq_q;
        end

        mask_s[CLS_NEG_INF]  = s1_cls_a_q.sign  & s1_cls_a_q.is_inf;
        mask_s[CLS_NEG_NORM] = s1_cls_a_q.sign  & s1_cls_a_q.is_norm;
        mask_s[CLS_NEG_SUB]  = s1_cls_a_q.sign  & s1_cls_a_q.is_sub;
        mask_s[CLS_NEG_ZERO] = s1_cls_a_q.sign  & s1_cls_a_q.is_zero;
        mask_s[CLS_POS_ZERO] = ~s1_cls_a_q.sign & s1_cls_a_q.is_zero;
        mask_s[CLS_POS_SUB]  = ~s1_cls_a_q.sign & s1_cls_a_q.is_sub;
        mask_s[CLS_POS_NORM] = ~s1_cls_a_q.sign & s1_cls_a_q.is_norm;
        mask_s[CLS_POS_INF]  = ~s1_cls_a_q.sign & s1_cls_a_q.is_inf;
        mask_s[CLS_SNAN]     = s1_cls_a_q.is_snan;
        mask_s[CLS_QNAN]     = s1_cls_a_q.is_qnan;

        case (s1_op_q)
            FP_FEQ: begin
                result_s = {{(XLEN-1){1'b0}}, eq_s};
                nv_s     = any_snan_s;
            end
            FP_FLT: begin
                result_s = {{(XLEN-1){1'b0}}, lt_s};
                nv_s     = any_nan_s;
            end
            FP_FLE: begin
                result_s = {{(XLEN-1){1'b0}}, lt_s | eq_s};
                nv_s     = any_nan_s;
            end
            FP_FCLASS: begin
                result_s = {{(XLEN-CLS_W){1'b0}}, mask_s};
                nv_s     = 1'b0;
            end
            default: begin
                result_s = {XLEN{1'b0}};
                nv_s     = 1'b0;
            end
        endcase
    end

    // Stage 2 next state: load from stage 1 when advancing, flush kills valid
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;
        s2_fflags_d = s2_fflags_q;
        if (s2_en_s && s1_valid_q) begin
            s2_result_d           = result_s;
            s2_tag_d              = s1_tag_q;
            s2_fflags_d           = {FFLAGS_W{1'b0}};
            s2_fflags_d[FFLAG_NV] = nv_s;
        end else begin
            s2_result_d = s2_result_q;
        end
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_en_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline state registers, cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= 2'b00;
            s1_tag_q    <= {TAG_W{1'b0}};
            s1_cls_a_q  <= '0;
            s1_cls_b_q  <= '0;
            s1_mag_eq_q <= 1'b0;
            s1_mag_lt_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= {XLEN{1'b0}};
            s2_tag_q    <= {TAG_W{1'b0}};
            s2_fflags_q <= {FFLAGS_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s1_cls_a_q  <= s1_cls_a_d;
            s1_cls_b_q  <= s1_cls_b_d;
            s1_mag_eq_q <= s1_mag_eq_d;
            s1_mag_lt_q <= s1_mag_lt_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
            s2_fflags_q <= s2_fflags_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_tag    = s2_tag_q;
    assign out_fflags = s2_fflags_q;

endmodule
